// File: rtl/fft_bitrev_reorder.sv
// fft_bitrev_reorder
// Collects the bit-reversed output frames of a radix-2 SDF FFT into one bank
// of a ping-pong buffer. Each sample goes to address bitrev(wcnt). The other
// bank is streamed out in natural order, one sample per cycle, with registered
// outputs.
// Optional feature: define IFFT_SCALE_1_OVER_N_EN to scale every output by
// 1/NFFT, rounding half up. The scaling adds no latency.
module fft_bitrev_reorder #(
    parameter int INTEGER_SIZE = 6,
    parameter int FRACT_SIZE   = 12,
    parameter int NFFT         = 64
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               in_valid,
    input  logic                               in_start,
    input  logic [INTEGER_SIZE+FRACT_SIZE-1:0] serial_in_r,
    input  logic [INTEGER_SIZE+FRACT_SIZE-1:0] serial_in_i,
    output logic [INTEGER_SIZE+FRACT_SIZE-1:0] out_r,
    output logic [INTEGER_SIZE+FRACT_SIZE-1:0] out_i,
    output logic                               out_valid,
    output logic                               out_start,
    output logic                               frame_err
);

    localparam int DW    = INTEGER_SIZE + FRACT_SIZE;
    localparam int LOG2N = $clog2(NFFT);

    localparam logic [LOG2N-1:0] CNT_ZERO = {LOG2N{1'b0}};
    localparam logic [LOG2N-1:0] CNT_ONE  = {{(LOG2N-1){1'b0}}, 1'b1};
    localparam logic [LOG2N-1:0] CNT_LAST = {LOG2N{1'b1}};

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        READ = 1'b1
    } rd_state_t;

    // Mirror the address bits: an SDF pipeline emits frame index k in position bitrev(k).
    function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] a);
        logic [LOG2N-1:0] r;
        r = CNT_ZERO;
        for (int b = 0; b < LOG2N; b++) begin
            r[b] = a[LOG2N-1-b];
        end
        return r;
    endfunction

    // Optional 1/N output scaling: round half up, in one extra bit so the rounding add cannot wrap.
    function automatic logic [DW-1:0] scale(input logic [DW-1:0] s);
`ifdef IFFT_SCALE_1_OVER_N_EN
        logic signed [DW:0] ext;
        logic signed [DW:0] rnd;
        rnd            = {(DW+1){1'b0}};
        rnd[LOG2N-1]   = 1'b1;
        ext            = $signed({s[DW-1], s}) + rnd;
        ext            = ext >>> LOG2N;
        return ext[DW-1:0];
`else
        return s;
`endif
    endfunction

    // ping-pong storage: address = {bank, index}
    logic [2*DW-1:0]  mem [0:2*NFFT-1];

    logic [LOG2N-1:0] wcnt;
    logic [LOG2N-1:0] wcnt_next;
    logic             frame_open;
    logic             frame_open_next;
    logic             bank_sel;          // bank currently being written
    logic             err_next;
    logic             wr_en;
    logic [LOG2N-1:0] wr_addr;
    logic             swap;

    rd_state_t        state;
    rd_state_t        state_next;
    logic [LOG2N-1:0] rcnt;
    logic [LOG2N-1:0] rcnt_next;
    logic             rd_en;
    logic [2*DW-1:0]  rd_word;

    // Write side: frame tracking, resync detection and the frame-complete swap request.
    always_comb begin
        wcnt_next       = wcnt;
        frame_open_next = frame_open;
        err_next        = 1'b0;
        wr_en           = 1'b0;
        wr_addr         = CNT_ZERO;
        swap            = 1'b0;
        if (in_valid) begin
            if (in_start) begin
                // A start always opens a fresh frame; any partial frame is abandoned.
                wr_en           = 1'b1;
                wr_addr         = CNT_ZERO;
                wcnt_next       = CNT_ONE;
                frame_open_next = 1'b1;
                if (wcnt != CNT_ZERO) begin
                    err_next = 1'b1;
                end else begin
                    err_next = 1'b0;
                end
            end else if (frame_open) begin
                wr_en   = 1'b1;
                wr_addr = bitrev(wcnt);
                if (wcnt == CNT_LAST) begin
                    swap            = 1'b1;
                    wcnt_next       = CNT_ZERO;
                    frame_open_next = 1'b0;
                end else begin
                    wcnt_next = wcnt + CNT_ONE;
                end
            end else begin
                // Sample arrived outside any frame: drop it.
                wr_en = 1'b0;
            end
        end else begin
            wr_en = 1'b0;
        end
    end

    // Write-side state: counter, open-frame flag, bank select and the resync error pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wcnt       <= CNT_ZERO;
            frame_open <= 1'b0;
            bank_sel   <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            wcnt       <= wcnt_next;
            frame_open <= frame_open_next;
            bank_sel   <= swap ? ~bank_sel : bank_sel;
            frame_err  <= err_next;
        end
    end

    // Sample storage; the contents need no reset because a fresh frame is needed before any read.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[{bank_sel, wr_addr}] <= {serial_in_r, serial_in_i};
        end
    end

    // Read FSM next-state logic: a swap starts (or restarts) a natural-order sweep of the full bank.
    always_comb begin
        state_next = state;
        rcnt_next  = rcnt;
        rd_en      = 1'b0;
        case (state)
            IDLE: begin
                if (swap) begin
                    state_next = READ;
                    rcnt_next  = CNT_ZERO;
                end else begin
                    state_next = IDLE;
                end
            end
            READ: begin
                rd_en = 1'b1;
                if (rcnt == CNT_LAST) begin
                    rcnt_next = CNT_ZERO;
                    if (swap) begin
                        state_next = READ;
                    end else begin
                        state_next = IDLE;
                    end
                end else begin
                    rcnt_next = rcnt + CNT_ONE;
                end
            end
            default: begin
                state_next = IDLE;
                rcnt_next  = CNT_ZERO;
            end
        endcase
    end

    // Read FSM state and read address registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            rcnt  <= CNT_ZERO;
        end else begin
            state <= state_next;
            rcnt  <= rcnt_next;
        end
    end

    // Read the bank that is not being written.
    always_comb begin
        rd_word = {(2*DW){1'b0}};
        rd_word = mem[{~bank_sel, rcnt}];
    end

    // Output registers: they load only while reading, so they hold their last value otherwise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_start <= 1'b0;
            out_r     <= {DW{1'b0}};
            out_i     <= {DW{1'b0}};
        end else begin
            out_valid <= rd_en;
            out_start <= rd_en && (rcnt == CNT_ZERO);
            if (rd_en) begin
                out_r <= scale(rd_word[2*DW-1:DW]);
                out_i <= scale(rd_word[DW-1:0]);
            end
        end
    end

endmodule

// File: tb/tb_fft_bitrev_reorder.sv
// Testbench for fft_bitrev_reorder (NFFT=64).
// A frame-level model collects the accepted samples and reorders each complete
// frame into natural order. It then queues every expected output word together
// with the cycle in which that word must appear. A negedge monitor pops and
// compares the queued words.
module tb_fft_bitrev_reorder;

    localparam int IS = 6;
    localparam int FS = 12;
    localparam int N  = 64;
    localparam int DW = IS + FS;
    localparam int LG = 6;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_start;
    logic [DW-1:0] sr;
    logic [DW-1:0] si;
    logic [DW-1:0] out_r;
    logic [DW-1:0] out_i;
    logic          out_valid;
    logic          out_start;
    logic          frame_err;

    fft_bitrev_reorder #(.INTEGER_SIZE(IS), .FRACT_SIZE(FS), .NFFT(N)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_start(in_start),
        .serial_in_r(sr), .serial_in_i(si),
        .out_r(out_r), .out_i(out_i), .out_valid(out_valid),
        .out_start(out_start), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [DW-1:0] r;
        logic [DW-1:0] i;
        bit            start;
        int            at;
    } exp_t;

    exp_t            exp_q[$];
    int              err_q[$];
    logic [2*DW-1:0] fbuf[$];
    int              n_chk  = 0;
    int              n_fail = 0;
    logic [DW-1:0]   last_r = '0;
    logic [DW-1:0]   last_i = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: actual %0h required %0h", name, cyc, act, req);
        end
    endtask

    // Arithmetic bit reversal: peel off the low bits with division.
    function automatic int rev(input int n);
        int r = 0;
        int v = n;
        for (int b = 0; b < LG; b++) begin
            r = r * 2 + (v % 2);
            v = v / 2;
        end
        return r;
    endfunction

    // Output value the model expects for one stored component.
    function automatic logic [DW-1:0] expv(input logic [DW-1:0] x);
`ifdef IFFT_SCALE_1_OVER_N_EN
        int v;
        int q;
        v = $signed(x);
        v = v + N / 2;
        if (v >= 0) q = v / N;
        else q = -((-v + N - 1) / N);
        return DW'(q);
`else
        return x;
`endif
    endfunction

    // Frame-level reference model: applies the acceptance rules to each presented sample.
    task automatic model_accept(input bit s, input logic [2*DW-1:0] w);
        exp_t e;
        if (s) begin
            if (fbuf.size() != 0) err_q.push_back(cyc + 1);
            fbuf.delete();
            fbuf.push_back(w);
        end else if (fbuf.size() != 0) begin
            fbuf.push_back(w);
        end
        if (fbuf.size() == N) begin
            for (int n = 0; n < N; n++) begin
                e.r     = expv(fbuf[rev(n)][2*DW-1:DW]);
                e.i     = expv(fbuf[rev(n)][DW-1:0]);
                e.start = (n == 0);
                e.at    = cyc + 2 + n;
                exp_q.push_back(e);
            end
            fbuf.delete();
        end
    endtask

    task automatic drive(input bit v, input bit s, input logic [DW-1:0] r, input logic [DW-1:0] i);
        @(posedge clk);
        #1;
        in_valid = v;
        in_start = s;
        sr       = r;
        si       = i;
        if (v && !rst) model_accept(s, {r, i});
    endtask

    task automatic idle(input int n);
        for (int c = 0; c < n; c++) drive(1'b0, 1'b0, '0, '0);
    endtask

    task automatic drain();
        for (int t = 0; t < 400 && exp_q.size() != 0; t++) idle(1);
        idle(2);
        check("drain_pending", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic check_reset_outputs();
        check("rst_out_r", 64'(out_r), 64'd0);
        check("rst_out_i", 64'(out_i), 64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_start", 64'(out_start), 64'd0);
        check("rst_frame_err", 64'(frame_err), 64'd0);
    endtask

    // Monitor: checks frame_err every cycle, and pops and compares expected outputs whenever out_valid is high.
    always @(negedge clk) begin
        exp_t e;
        bit   ee;
        if (rst) begin
            last_r = '0;
            last_i = '0;
        end else begin
            ee = (err_q.size() != 0) && (err_q[0] == cyc);
            if (ee) void'(err_q.pop_front());
            check("frame_err", 64'(frame_err), 64'(ee));
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    check("spurious_out_valid", 64'(out_valid), 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("out_data", {28'd0, out_r, out_i}, {28'd0, e.r, e.i});
                    check("out_start", 64'(out_start), 64'(e.start));
                    check("out_timing", 64'(cyc), 64'(e.at));
                end
                last_r = out_r;
                last_i = out_i;
            end else begin
                if (exp_q.size() != 0 && exp_q[0].at <= cyc) begin
                    check("missing_out_valid", 64'(out_valid), 64'd1);
                    void'(exp_q.pop_front());
                end
                check("hold_value", {28'd0, out_r, out_i}, {28'd0, last_r, last_i});
                check("start_without_valid", 64'(out_start), 64'd0);
            end
        end
    end

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        in_start = 1'b0;
        sr       = '0;
        si       = '0;
        #1;
        check_reset_outputs();
        idle(3);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Samples outside any frame are dropped.
        for (int k = 0; k < 5; k++) drive(1'b1, 1'b0, DW'(500 + k), DW'(7));
        idle(2);

        // Two back-to-back frames: ramp, then ramp + 100.
        for (int k = 0; k < N; k++) drive(1'b1, k == 0, DW'(k), DW'(-k));
        for (int k = 0; k < N; k++) drive(1'b1, k == 0, DW'(k + 100), DW'(-(k + 100)));
        drain();

        // Resync: a second start at k=20 abandons the partial frame.
        for (int k = 0; k < 20; k++) drive(1'b1, k == 0, DW'($urandom), DW'($urandom));
        for (int k = 0; k < N; k++) drive(1'b1, k == 0, DW'($urandom), DW'($urandom));
        drain();

        // Frame with in_valid low every other cycle.
        for (int k = 0; k < N; k++) begin
            drive(1'b1, k == 0, DW'(3 * k), DW'(-(5 * k)));
            idle(1);
        end
        drain();

        // Reset in the middle of the second frame, while the first frame is still streaming out.
        for (int k = 0; k < N; k++) drive(1'b1, k == 0, DW'($urandom), DW'($urandom));
        for (int k = 0; k < 40; k++) drive(1'b1, k == 0, DW'($urandom), DW'($urandom));
        @(posedge clk);
        #1;
        check("valid_before_rst", 64'(out_valid), 64'd1);
        rst      = 1'b1;
        in_valid = 1'b0;
        in_start = 1'b0;
        exp_q.delete();
        err_q.delete();
        fbuf.delete();
        #1;
        check_reset_outputs();
        idle(3);
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int k = 0; k < 24; k++) drive(1'b1, 1'b0, DW'($urandom), DW'($urandom));
        idle(3);
        for (int k = 0; k < N; k++) drive(1'b1, k == 0, DW'($urandom), DW'($urandom));
        drain();

        // Random frames with random input gaps, including scaling corner values.
        for (int f = 0; f < 3; f++) begin
            for (int k = 0; k < N; k++) begin
                logic [DW-1:0] rv;
                rv = DW'($urandom);
                if (k == 1) rv = DW'(96);
                if (k == 2) rv = DW'(-33);
                if (k == 3) rv = DW'(31);
                while ($urandom_range(0, 3) == 0) idle(1);
                drive(1'b1, k == 0, rv, DW'($urandom));
            end
        end
        drain();

        check("err_pending", 64'(err_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
